// File: rtl/uart_pkg.sv
// uart_pkg: shared deframer states, default sync marker and timeout sizing
package uart_pkg;
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, HOLD} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic int timeout_cyc(input int bits, input int clk_mhz, input int baud);
    return int'(longint'(bits) * longint'(clk_mhz) * 64'sd1000000 / longint'(baud));
  endfunction
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload byte storage with a write port and a registered read port
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // payload write, no reset needed since only committed entries are ever read
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read, holds its value while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: sync/length/payload frame assembler; UART_DEFRAMER_CHKSUM_EN adds a trailing XOR checksum byte
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int         CLK_FRE      = 50,
  parameter int         BAUD_RATE    = 115200,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_ack,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_last,
  input  logic       m_rdy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_tmo
);
  localparam int TMO = timeout_cyc(TIMEOUT_BITS, CLK_FRE, BAUD_RATE);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  state_t state, state_nxt;
  logic armed, accept, counting, tmo_hit, len_bad, pay_last, load, done;
  logic [PW-1:0] len, wptr, rptr;
  logic [CW-1:0] cnt;
  assign accept   = rx_rdy && armed && state != HOLD;
  assign counting = state == LEN || state == PAYLOAD || state == CHK;
  assign tmo_hit  = counting && !accept && cnt == TMO_LAST;
  assign len_bad  = rx_data == 8'd0 || rx_data > 8'(MAX_LEN);
  assign pay_last = wptr + P1 == len;
  assign load     = state == HOLD && (!m_vld || (m_rdy && !m_last));
  assign done     = state == HOLD && m_vld && m_rdy && m_last;
`ifdef UART_DEFRAMER_CHKSUM_EN
  logic [7:0] chk;
  // running XOR seeded with the length, compared against the trailing byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chk     <= '0;
      err_chk <= 1'b0;
    end else begin
      err_chk <= accept && state == CHK && rx_data != chk;
      chk     <= (accept && state == LEN) ? rx_data : (accept && state == PAYLOAD) ? chk ^ rx_data : chk;
    end
`else
  assign err_chk = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  // next state; a timeout only fires when no byte is accepted that cycle
  always_comb begin
    state_nxt = state;
    if (tmo_hit) state_nxt = HUNT;
    else if (done) state_nxt = HUNT;
    else if (accept)
      case (state)
        HUNT:    state_nxt = rx_data == SYNC_BYTE ? LEN : HUNT;
        LEN:     state_nxt = len_bad ? HUNT : PAYLOAD;
`ifdef UART_DEFRAMER_CHKSUM_EN
        PAYLOAD: state_nxt = pay_last ? CHK : PAYLOAD;
        CHK:     state_nxt = rx_data == chk ? HOLD : HUNT;
`else
        PAYLOAD: state_nxt = pay_last ? HOLD : PAYLOAD;
`endif
        default: state_nxt = state;
      endcase
  end
  // byte handshake, pointers, timeout counter and drain control
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed   <= 1'b1;
      rx_ack  <= 1'b0;
      err_len <= 1'b0;
      err_tmo <= 1'b0;
      len     <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      m_vld   <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      armed   <= !rx_rdy || (armed && !accept);
      rx_ack  <= accept;
      err_len <= accept && state == LEN && len_bad;
      err_tmo <= tmo_hit;
      cnt     <= (accept || !counting) ? '0 : cnt + C1;
      if (accept && state == LEN) len <= rx_data[PW-1:0];
      wptr    <= (accept && state == LEN) ? '0 : (accept && state == PAYLOAD) ? wptr + P1 : wptr;
      rptr    <= state != HOLD ? '0 : load ? rptr + P1 : rptr;
      m_vld   <= load || (m_vld && !done);
      m_last  <= load ? rptr + P1 == len : m_last && !done;
    end
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept && state == PAYLOAD),
    .waddr (wptr[AW-1:0]),
    .wdata (rx_data),
    .re    (load),
    .raddr (rptr[AW-1:0]),
    .rdata (m_data)
  );
endmodule
